// File: rtl/controlador_fetch_mem.sv
// Fetch/load initiator for the main-memory read port: owns the PC, issues reads, presents results.
// Optional macro FETCH_ALIGN_CHECK_EN: stall fetching on a misaligned PC and raise align_err.
module controlador_fetch_mem #(
    parameter int             bus     = 31,
    parameter logic [bus:0]   PC_BASE = 32'h00400000,
    parameter logic [bus:0]   PC_MAX  = 32'h00400038,
    parameter int             PC_STEP = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           pc_load,
    input  logic [bus:0]   pc_new,
    output logic [bus:0]   instr,
    output logic [bus:0]   pc_instr,
    output logic           instr_valid,
    input  logic           instr_ready,
    input  logic           ld_req,
    input  logic [bus:0]   ld_addr,
    output logic           ld_ack,
    output logic [bus:0]   ld_data,
    output logic           ld_valid,
    output logic           enable,
    output logic           ReadMem,
    output logic [bus:0]   Dir_Instru,
    output logic [bus:0]   Dir_Mem,
    input  logic [bus:0]   Dato_Instru,
    input  logic [bus:0]   Dato_Mem,
    output logic           align_err
);
    typedef enum logic [2:0] {IDLE, REQ_I, WAIT_I, HOLD, REQ_D, WAIT_D} state_t;

    localparam logic [bus:0] STEP = (bus+1)'(PC_STEP);

    state_t       state, state_next;
    logic [bus:0] pc, pc_next, pc_inc;
    logic         started;
    logic         redirect;
    logic         align_hit;
    logic         fetch_ok;

    assign pc_inc   = (pc == PC_MAX) ? PC_BASE : pc + STEP;
    assign redirect = pc_load && (state != IDLE);

`ifdef FETCH_ALIGN_CHECK_EN
    assign align_hit = (state == REQ_I) && (pc[1:0] != 2'b00);
    assign fetch_ok  = (pc_next[1:0] == 2'b00);
`else
    assign align_hit = 1'b0;
    assign fetch_ok  = 1'b1;
`endif

    always_comb begin
        state_next = state;
        pc_next    = pc;
        case (state)
            IDLE:   if (ld_req) state_next = REQ_D;
                    else if (start) state_next = REQ_I;
            REQ_I:  state_next = align_hit ? HOLD : WAIT_I;
            WAIT_I: begin
                state_next = HOLD;
                pc_next    = pc_inc;
            end
            HOLD:   if (ld_req) state_next = REQ_D;
                    else if (instr_valid && instr_ready) state_next = REQ_I;
                    else if (!instr_valid && !align_err) state_next = REQ_I;
            REQ_D:  state_next = WAIT_D;
            WAIT_D: state_next = started ? HOLD : IDLE;
            default: state_next = IDLE;
        endcase
        // A redirect wins over everything except an in-flight load, which still completes.
        if (redirect) begin
            pc_next = pc_new;
            if (state == REQ_I || state == WAIT_I || state == HOLD) state_next = REQ_I;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            pc          <= PC_BASE;
            started     <= 1'b0;
            instr       <= '0;
            pc_instr    <= '0;
            instr_valid <= 1'b0;
            ld_data     <= '0;
            ld_valid    <= 1'b0;
            ld_ack      <= 1'b0;
            enable      <= 1'b1;
            ReadMem     <= 1'b1;
            Dir_Instru  <= '0;
            Dir_Mem     <= '0;
            align_err   <= 1'b0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (state == IDLE && start) started <= 1'b1;

            // Memory controls are registered from the next state so they line up with REQ_*.
            enable  <= !(state_next == REQ_I && fetch_ok);
            ReadMem <= !(state_next == REQ_D);
            ld_ack  <= (state_next == REQ_D);
            if (state_next == REQ_I) Dir_Instru <= pc_next;
            if (state_next == REQ_D) Dir_Mem    <= ld_addr;

            ld_valid <= (state == WAIT_D);
            if (state == WAIT_D) ld_data <= Dato_Mem;

            if (redirect) begin
                instr_valid <= 1'b0;
            end else if (state == WAIT_I) begin
                instr       <= Dato_Instru;
                pc_instr    <= pc;
                instr_valid <= 1'b1;
            end else if (state == HOLD && instr_valid && instr_ready && !ld_req) begin
                instr_valid <= 1'b0;
            end

`ifdef FETCH_ALIGN_CHECK_EN
            if (redirect) begin
                if (pc_new[1:0] == 2'b00) align_err <= 1'b0;
            end else if (align_hit) begin
                align_err <= 1'b1;
            end
`else
            align_err <= 1'b0;
`endif
        end
    end
endmodule
